// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared constants and scheduler state type for the FC1_LIF1 stage
// Contents:
//   DEF_INPUT_NODES / DEF_OUTPUT_NODES / DEF_STEP : layer geometry shared with FC1_LIF1
//   DEF_WAIT_MAX                                  : spike-valid timeout default
//   sched_state_t                                 : snn_step_scheduler FSM states
package snn_pkg;

  localparam int DEF_INPUT_NODES  = 784;
  localparam int DEF_OUTPUT_NODES = 20;
  localparam int DEF_STEP         = 25;
  localparam int DEF_WAIT_MAX     = 15;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_WAIT   = 3'd2,
    S_NEXT   = 3'd3,
    S_RESULT = 3'd4,
    S_DONE   = 3'd5
  } sched_state_t;

endpackage

// File: rtl/spike_counter_bank.sv
// rtl/spike_counter_bank.sv - per-neuron spike accumulators
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : zero every counter (wins over add_en)
//   add_en       : add spk[i] into counter i this cycle
//   spk          : one spike bit per neuron
//   cnt          : flattened counters, neuron i at [i*CNT_W +: CNT_W]
module spike_counter_bank #(
  parameter int OUTPUT_NODES = 20,
  parameter int CNT_W        = 5
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clear,
  input  logic                          add_en,
  input  logic [OUTPUT_NODES-1:0]       spk,
  output logic [OUTPUT_NODES*CNT_W-1:0] cnt
);

  // CNT_W is sized to hold STEP, and at most one add happens per timestep,
  // so the counters cannot wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (add_en) begin
      for (int i = 0; i < OUTPUT_NODES; i++) begin
        cnt[i*CNT_W +: CNT_W] <= cnt[i*CNT_W +: CNT_W] + CNT_W'(spk[i]);
      end
    end
  end

endmodule

// File: rtl/snn_step_scheduler.sv
// rtl/snn_step_scheduler.sv - timestep sequencer driving FC1_LIF1 read windows and spike counting
// Optional feature macro: SNN_SCHED_ARGMAX_EN (adds class_id and the argmax scan)
// Ports:
//   clk, reset_n    : clock, asynchronous active-low reset (shared with FC1_LIF1)
//   start           : one-cycle request, honoured only in IDLE
//   busy            : high from the cycle after an accepted start until done
//   fc_addra_valid  : layer read-window strobe, INPUT_NODES+1 cycles per timestep
//   pix_addr        : encoder pixel index during the window, 0 otherwise
//   step_idx        : current timestep
//   spk1_en, spk_1  : layer spike-valid pulse and spike vector
//   spk_cnt         : flattened per-neuron spike counts
//   done            : one-cycle completion pulse
//   err             : sticky error (timeout or spk1_en outside WAIT)
//   class_id        : argmax neuron index (macro builds only)
module snn_step_scheduler
  import snn_pkg::*;
#(
  parameter int INPUT_NODES  = DEF_INPUT_NODES,
  parameter int OUTPUT_NODES = DEF_OUTPUT_NODES,
  parameter int STEP         = DEF_STEP,
  parameter int WAIT_MAX     = DEF_WAIT_MAX,
  parameter int CNT_W        = $clog2(STEP + 1)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          fc_addra_valid,
  output logic [9:0]                    pix_addr,
  output logic [4:0]                    step_idx,
  input  logic                          spk1_en,
  input  logic [OUTPUT_NODES-1:0]       spk_1,
  output logic [OUTPUT_NODES*CNT_W-1:0] spk_cnt,
  output logic                          done,
  output logic                          err
`ifdef SNN_SCHED_ARGMAX_EN
  ,
  output logic [4:0]                    class_id
`endif
);

  localparam int WW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [9:0]    LAST_PIX  = 10'(INPUT_NODES);
  localparam logic [4:0]    LAST_STEP = 5'(STEP - 1);
  localparam logic [WW-1:0] LAST_WAIT = WW'(WAIT_MAX - 1);

  sched_state_t  state;
  logic [WW-1:0] wait_cnt;
  logic          cnt_clear;
  logic          cnt_add;

  // Counters clear on the same edge that accepts start and accumulate on
  // the edge that samples spk1_en in WAIT; strays elsewhere never count.
  assign cnt_clear = (state == S_IDLE) && start;
  assign cnt_add   = (state == S_WAIT) && spk1_en;

  spike_counter_bank #(
    .OUTPUT_NODES (OUTPUT_NODES),
    .CNT_W        (CNT_W)
  ) u_bank (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (cnt_clear),
    .add_en  (cnt_add),
    .spk     (spk_1),
    .cnt     (spk_cnt)
  );

`ifdef SNN_SCHED_ARGMAX_EN
  localparam int IW = (OUTPUT_NODES > 1) ? $clog2(OUTPUT_NODES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(OUTPUT_NODES - 1);

  logic [IW-1:0]    scan_idx;
  logic [IW-1:0]    run_idx;
  logic [CNT_W-1:0] run_max;
  logic [CNT_W-1:0] cnt_sel;
  logic             cand_better;

  always_comb begin
    cnt_sel = '0;
    for (int i = 0; i < OUTPUT_NODES; i++) begin
      if (scan_idx == IW'(i)) cnt_sel = spk_cnt[i*CNT_W +: CNT_W];
    end
  end

  // Strict compare: on ties the earlier (lower) index is kept.
  assign cand_better = cnt_sel > run_max;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      fc_addra_valid <= 1'b0;
      pix_addr       <= '0;
      step_idx       <= '0;
      wait_cnt       <= '0;
      done           <= 1'b0;
      err            <= 1'b0;
`ifdef SNN_SCHED_ARGMAX_EN
      scan_idx       <= '0;
      run_idx        <= '0;
      run_max        <= '0;
      class_id       <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (spk1_en && (state != S_WAIT)) err <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start) begin
            state          <= S_DRIVE;
            busy           <= 1'b1;
            fc_addra_valid <= 1'b1;
            pix_addr       <= '0;
            step_idx       <= '0;
            err            <= 1'b0;
`ifdef SNN_SCHED_ARGMAX_EN
            class_id       <= '0;
`endif
          end
        end

        // The layer's address counter wraps after exactly INPUT_NODES+1
        // strobed cycles, so the window length is fixed.
        S_DRIVE: begin
          if (pix_addr == LAST_PIX) begin
            state          <= S_WAIT;
            fc_addra_valid <= 1'b0;
            pix_addr       <= '0;
            wait_cnt       <= '0;
          end else begin
            pix_addr <= pix_addr + 10'd1;
          end
        end

        S_WAIT: begin
          if (spk1_en) begin
            state <= S_NEXT;
          end else if (wait_cnt == LAST_WAIT) begin
            state <= S_DONE;
            err   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end

        // NEXT always sits between windows, giving the layer the low
        // strobe cycle its edge detector needs.
        S_NEXT: begin
          if (step_idx == LAST_STEP) begin
`ifdef SNN_SCHED_ARGMAX_EN
            state    <= S_RESULT;
            scan_idx <= '0;
            run_idx  <= '0;
            run_max  <= '0;
`else
            state    <= S_DONE;
            done     <= 1'b1;
            busy     <= 1'b0;
`endif
          end else begin
            state          <= S_DRIVE;
            step_idx       <= step_idx + 5'd1;
            fc_addra_valid <= 1'b1;
            pix_addr       <= '0;
          end
        end

        S_RESULT: begin
`ifdef SNN_SCHED_ARGMAX_EN
          if (cand_better) begin
            run_max <= cnt_sel;
            run_idx <= scan_idx;
          end
          if (scan_idx == LAST_IDX) begin
            class_id <= cand_better ? 5'(scan_idx) : 5'(run_idx);
            state    <= S_DONE;
            done     <= 1'b1;
            busy     <= 1'b0;
          end else begin
            scan_idx <= scan_idx + IW'(1);
          end
`else
          state <= S_DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
`endif
        end

        // A start seen here is dropped; IDLE accepts on the next cycle.
        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snn_step_scheduler.sv
// tb/tb_snn_step_scheduler.sv - directed bench for snn_step_scheduler (8 pixels, 4 neurons, 3 steps)
module tb_snn_step_scheduler;

  localparam int INPUT_NODES  = 8;
  localparam int OUTPUT_NODES = 4;
  localparam int STEP         = 3;
  localparam int WAIT_MAX     = 15;
  localparam int CNT_W        = 2;
`ifdef SNN_SCHED_ARGMAX_EN
  localparam int DONE_LAT     = 2 + OUTPUT_NODES;
`else
  localparam int DONE_LAT     = 2;
`endif

  logic                          clk;
  logic                          reset_n;
  logic                          start;
  logic                          busy;
  logic                          fc_addra_valid;
  logic [9:0]                    pix_addr;
  logic [4:0]                    step_idx;
  logic                          spk1_en;
  logic [OUTPUT_NODES-1:0]       spk_1;
  logic [OUTPUT_NODES*CNT_W-1:0] spk_cnt;
  logic                          done;
  logic                          err;
`ifdef SNN_SCHED_ARGMAX_EN
  logic [4:0]                    class_id;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  snn_step_scheduler #(
    .INPUT_NODES  (INPUT_NODES),
    .OUTPUT_NODES (OUTPUT_NODES),
    .STEP         (STEP),
    .WAIT_MAX     (WAIT_MAX),
    .CNT_W        (CNT_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .busy           (busy),
    .fc_addra_valid (fc_addra_valid),
    .pix_addr       (pix_addr),
    .step_idx       (step_idx),
    .spk1_en        (spk1_en),
    .spk_1          (spk_1),
    .spk_cnt        (spk_cnt),
    .done           (done),
    .err            (err)
`ifdef SNN_SCHED_ARGMAX_EN
    ,
    .class_id       (class_id)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [11:0] pats;      // step s pattern in pats[s*4 +: 4]
    bit          pulses;    // layer model produces spk1_en
    bit          inject;    // re-pulse start and stray spk1_en in window 0
    logic [7:0]  exp_cnt;   // {n3,n2,n1,n0}
    logic        exp_err;
    logic [4:0]  exp_class;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic run_inference(input vec_t v, input bit restart_at_done);
    int win_len;
    int pix_bad;
    int guard;
    int lat;
    logic [CNT_W-1:0] model [OUTPUT_NODES];
    logic [7:0] model_flat;
    for (int i = 0; i < OUTPUT_NODES; i++) model[i] = '0;

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", busy, 1);
    check("err_clear_on_start", err, 0);

    for (int s = 0; s < STEP; s++) begin
      guard = 0;
      while (fc_addra_valid !== 1'b1 && guard < 10) begin
        @(negedge clk);
        guard++;
      end
      check("window_gap", guard, (s == 0) ? 0 : 1);

      win_len = 0;
      pix_bad = 0;
      while (fc_addra_valid === 1'b1 && win_len < 20) begin
        if (pix_addr !== 10'(win_len)) pix_bad++;
        if (v.inject && s == 0 && win_len == 2) begin
          start   = 1'b1;
          spk1_en = 1'b1;
          spk_1   = 4'hF;
        end
        @(negedge clk);
        start   = 1'b0;
        spk1_en = 1'b0;
        spk_1   = '0;
        win_len++;
      end
      check("window_len", win_len, INPUT_NODES + 1);
      check("pix_seq_errors", pix_bad, 0);
      check("step_idx", step_idx, s);

      if (!v.pulses) begin
        lat = 0;
        while (err !== 1'b1 && lat < 40) begin
          @(negedge clk);
          lat++;
        end
        check("err_timeout_lat", lat, WAIT_MAX);
        check("timeout_done", done, 1);
        check("timeout_busy", busy, 0);
        break;
      end

      repeat (4) @(negedge clk);
      spk1_en = 1'b1;
      spk_1   = v.pats[s*4 +: 4];
      for (int i = 0; i < OUTPUT_NODES; i++) model[i] = model[i] + CNT_W'(spk_1[i]);
      @(negedge clk);
      spk1_en = 1'b0;
      spk_1   = '0;
      for (int i = 0; i < OUTPUT_NODES; i++) model_flat[i*CNT_W +: CNT_W] = model[i];
      check("cnt_after_step", spk_cnt, model_flat);

      if (s == STEP - 1) begin
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
          @(negedge clk);
          lat++;
        end
        check("done_latency", lat, DONE_LAT);
        check("busy_fall_with_done", busy, 0);
      end
    end

    check("final_cnt", spk_cnt, v.exp_cnt);
    check("final_err", err, v.exp_err);
`ifdef SNN_SCHED_ARGMAX_EN
    check("class_id", class_id, v.exp_class);
`endif

    if (restart_at_done) begin
      start = 1'b1;
      @(negedge clk);
      check("start_at_done_ignored", busy, 0);
      check("start_at_done_no_window", fc_addra_valid, 0);
      @(negedge clk);
      start = 1'b0;
      check("start_after_done_busy", busy, 1);
      check("start_after_done_window", fc_addra_valid, 1);
    end else begin
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("idle_busy", busy, 0);
    end
  endtask

  initial begin
    int g;
    vecs[0] = '{12'hAAA, 1'b1, 1'b0, 8'hCC, 1'b0, 5'd1};
    vecs[1] = '{12'h000, 1'b0, 1'b0, 8'h00, 1'b1, 5'd0};
    vecs[2] = '{12'h246, 1'b1, 1'b1, 8'h28, 1'b1, 5'd1};
    vecs[3] = '{12'h81F, 1'b1, 1'b0, 8'h96, 1'b0, 5'd0};
    vecs[4] = '{12'h000, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0};
    vecs[5] = '{12'h888, 1'b1, 1'b0, 8'hC0, 1'b0, 5'd3};

    reset_n = 1'b0;
    start   = 1'b0;
    spk1_en = 1'b0;
    spk_1   = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", fc_addra_valid, 0);
    check("rst_pix", pix_addr, 0);
    check("rst_step", step_idx, 0);
    check("rst_cnt", spk_cnt, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset dropped in the 4th cycle of window 2
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    g = 0;
    while (fc_addra_valid === 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    repeat (4) @(negedge clk);
    spk1_en = 1'b1;
    spk_1   = 4'b1010;
    @(negedge clk);
    spk1_en = 1'b0;
    spk_1   = '0;
    g = 0;
    while (fc_addra_valid !== 1'b1 && g < 10) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(negedge clk);
    check("mid_pix_before_reset", pix_addr, 3);
    check("mid_cnt_before_reset", spk_cnt, 8'h44);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", fc_addra_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cnt", spk_cnt, 0);
    check("mid_rst_step", step_idx, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      run_inference(vecs[k], 1'b0);
      repeat (2) @(negedge clk);
    end

    // start coinciding with done is dropped, next cycle's start is taken
    run_inference(vecs[0], 1'b1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
